// File: rtl/sar_search.sv
// Successive-approximation search master: drives probe to an external magnitude comparator
// and resolves the unknown value one bit per clock. Optional SAR_CHECK_EN flags inconsistent responses.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH-1);
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] next_bit;

  // Anything that is not eq or gt counts as "unknown below probe", including no response.
  assign acc_next = gt_in ? probe : acc;
  assign next_bit = ONE << (idx - IW'(1));

`ifdef SAR_CHECK_EN
  logic err_q;
  logic bad_resp;
  assign bad_resp = ({1'b0, gt_in} + {1'b0, lt_in} + {1'b0, eq_in}) != 2'd1;
  assign error    = err_q;
`else
  logic unused_lt;
  assign unused_lt = lt_in;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= TOP_IDX;
      acc    <= '0;
      probe  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      exact  <= 1'b0;
`ifdef SAR_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= PROBE;
            idx    <= TOP_IDX;
            acc    <= '0;
            probe  <= MSB;
            result <= '0;
            exact  <= 1'b0;
            busy   <= 1'b1;
`ifdef SAR_CHECK_EN
            err_q  <= 1'b0;
`endif
          end
        end

        PROBE: begin
`ifdef SAR_CHECK_EN
          if (bad_resp) begin
            err_q  <= 1'b1;
            result <= '0;
            exact  <= 1'b0;
            probe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else
`endif
          if (eq_in) begin
            result <= probe;
            exact  <= 1'b1;
            probe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= acc_next;
            if (idx != '0) begin
              probe <= acc_next | next_bit;
              idx   <= idx - IW'(1);
            end else begin
              // Every bit resolved without an eq: the value is inferred from the accumulator.
              result <= acc_next;
              exact  <= 1'b0;
              probe  <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          probe <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: comparator model driven from probe, scoreboard of expected outcomes.
module tb_sar_search;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         gt_in, lt_in, eq_in;
  logic [W-1:0] probe, result;
  logic         busy, done, exact, error;

  logic [W-1:0] unknown = '0;
  logic         ovr_first = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         ex;
    logic         err;
    int           nprobe;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] probe_q[$];

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
    .probe(probe), .busy(busy), .done(done),
    .result(result), .exact(exact), .error(error)
  );

  always #5 clk = ~clk;

  // External comparator; ovr_first forces an inconsistent gt+lt response.
  always_comb begin
    if (ovr_first) begin
      gt_in = 1'b1; lt_in = 1'b1; eq_in = 1'b0;
    end else begin
      gt_in = unknown > probe;
      lt_in = unknown < probe;
      eq_in = unknown == probe;
    end
  end

  function automatic int probes_for(input logic [W-1:0] u);
    for (int b = 0; b < W; b++) if (u[b]) return W - b;
    return W;
  endfunction

  task automatic push_normal(input logic [W-1:0] u);
    exp_t e;
    e.res = u; e.ex = (u != 0); e.err = 1'b0; e.nprobe = probes_for(u);
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [W-1:0] unk, input int pulse_at, input bit ovr);
    exp_t         e;
    int           cyc;
    logic [W-1:0] seen[$];
    logic [W-1:0] held;
    @(negedge clk);
    unknown = unk; ovr_first = ovr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc <= 3*W) begin
      if (busy === 1'b1) seen.push_back(probe);
      start = (cyc == pulse_at);
      @(negedge clk);
      ovr_first = 1'b0;
      cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL timeout unk=%0d: done never rose", unk);
    end
    n_cmp++;
    if (cyc != e.nprobe + 1) begin
      n_bad++; $display("FAIL latency unk=%0d: got %0d want %0d", unk, cyc, e.nprobe + 1);
    end
    n_cmp++;
    if (result !== e.res) begin
      n_bad++; $display("FAIL result unk=%0d: got %0d want %0d", unk, result, e.res);
    end
    n_cmp++;
    if (exact !== e.ex) begin
      n_bad++; $display("FAIL exact unk=%0d: got %b want %b", unk, exact, e.ex);
    end
    n_cmp++;
    if (error !== e.err) begin
      n_bad++; $display("FAIL error unk=%0d: got %b want %b", unk, error, e.err);
    end
    n_cmp++;
    if (probe !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_state unk=%0d: probe=%0d busy=%b want 0/0", unk, probe, busy);
    end
    n_cmp++;
    if (seen.size() != e.nprobe) begin
      n_bad++; $display("FAIL probe_count unk=%0d: got %0d want %0d", unk, seen.size(), e.nprobe);
    end
    if (probe_q.size() > 0) begin
      for (int i = 0; i < probe_q.size() && i < seen.size(); i++) begin
        n_cmp++;
        if (seen[i] !== probe_q[i]) begin
          n_bad++; $display("FAIL probe_seq unk=%0d step %0d: got %0d want %0d", unk, i, seen[i], probe_q[i]);
        end
      end
      probe_q.delete();
    end
    held = result;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || result !== e.res || held !== e.res) begin
      n_bad++; $display("FAIL hold unk=%0d: done=%b result=%0d want 0/%0d", unk, done, result, e.res);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({probe, result, busy, done, exact, error} !== '0) begin
      n_bad++; $display("FAIL reset_state: probe=%0d result=%0d busy=%b done=%b exact=%b error=%b want all 0",
                        probe, result, busy, done, exact, error);
    end
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    push_normal(4'd5);  probe_q = '{4'd8, 4'd4, 4'd6, 4'd5};   run(4'd5, 0, 1'b0);
    push_normal(4'd0);  probe_q = '{4'd8, 4'd4, 4'd2, 4'd1};   run(4'd0, 0, 1'b0);
    push_normal(4'd8);  probe_q = '{4'd8};                     run(4'd8, 0, 1'b0);
    push_normal(4'd15); probe_q = '{4'd8, 4'd12, 4'd14, 4'd15}; run(4'd15, 2, 1'b0);
  endtask

  task automatic test_sweep();
    for (int u = 0; u < (1 << W); u++) begin
      push_normal(W'(u));
      run(W'(u), (u % 3) + 1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    unknown = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 3) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({probe, result, busy, done, exact, error} !== '0) begin
      n_bad++; $display("FAIL reset_mid: probe=%0d result=%0d busy=%b done=%b want all 0", probe, result, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_no_done: got %b want 0", done); end
    end
    reset = 1'b0;
    push_normal(4'd3); probe_q = '{4'd8, 4'd4, 4'd2, 4'd3};
    run(4'd3, 0, 1'b0);
  endtask

  task automatic test_start_in_done();
    @(negedge clk);
    unknown = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got %b want 1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || probe !== '0) begin
      n_bad++; $display("FAIL start_in_done: busy=%b probe=%0d want 0/0", busy, probe);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL no_queue: busy=%b want 0", busy); end
  endtask

  task automatic test_check_en();
    exp_t e;
`ifdef SAR_CHECK_EN
    e.res = 4'd0; e.ex = 1'b0; e.err = 1'b1; e.nprobe = 1;
    exp_q.push_back(e); probe_q = '{4'd8};
`else
    e.res = 4'd10; e.ex = 1'b1; e.err = 1'b0; e.nprobe = 3;
    exp_q.push_back(e); probe_q = '{4'd8, 4'd12, 4'd10};
`endif
    run(4'd10, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_normal(4'd7);  run(4'd7, 0, 1'b0);
    push_normal(4'd1);  run(4'd1, 0, 1'b0);
    push_normal(4'd12); run(4'd12, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_sweep();
    test_reset_mid();
    test_start_in_done();
    test_check_en();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
